// File: rtl/user_key_ctrl_pkg.sv
// Shared definitions for the push-button peripheral: register map, pin reset level
// and the popcount helper used by the press counter.
package user_key_ctrl_pkg;

  typedef enum logic [1:0] {
    KEY_STATUS = 2'd0,
    KEY_PRESS  = 2'd1,
    KEY_IRQEN  = 2'd2,
    KEY_COUNT  = 2'd3
  } key_reg_e;

  // Idle level of the active-low raw pins; synchroniser stages reset to it.
  localparam logic [7:0] KEY_PIN_RESET = 8'hFF;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/user_key_ctrl_if.sv
// CPU peripheral-bridge side of the key controller: word-select bus and interrupt.
interface user_key_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/user_key_ctrl_debounce.sv
// One key: 2-FF synchroniser, stability counter and accepted level, plus a
// single-cycle pulse on the edge where a press is accepted.
module key_debounce #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_LVL         = 1'b1
) (
  input  logic clk_in,
  input  logic sys_rstn,
  input  logic key_raw,
  output logic stable,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;
  logic          pressed_s;
  logic          accept_s;

  // Pressed level is the inverted synchronised pin; accept after a full stable run.
  always_comb begin
    pressed_s = ~sync2_r;
    accept_s  = (pressed_s != stable_r) && (cnt_r == CW'(DEBOUNCE_CYCLES - 1));
  end

  // Synchroniser and debounce state; any return to the accepted level restarts the count.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync1_r  <= RST_LVL;
      sync2_r  <= RST_LVL;
      stable_r <= 1'b0;
      cnt_r    <= CW'(0);
    end else begin
      sync1_r <= key_raw;
      sync2_r <= sync1_r;
      if (pressed_s == stable_r) begin
        cnt_r <= CW'(0);
      end else if (accept_s) begin
        stable_r <= pressed_s;
        cnt_r    <= CW'(0);
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign stable = stable_r;
  assign rise   = accept_s & pressed_s;

endmodule

// File: rtl/user_key_ctrl.sv
// Push-button peripheral top: per-key debouncers, sticky press flags, interrupt
// mask, saturating press counter and the level interrupt to CP0.
module user_key_ctrl
  import user_key_ctrl_pkg::*;
#(
  parameter int KEYS            = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 32
) (
  input  logic             clk_in,
  input  logic             sys_rstn,
  input  logic [KEYS-1:0]  user_key,
  user_key_ctrl_if.slave   bus
);
  logic [KEYS-1:0]  stable_s;
  logic [KEYS-1:0]  rise_s;
  logic [KEYS-1:0]  clr_s;
  logic [KEYS-1:0]  press_r;
  logic [KEYS-1:0]  press_nxt_s;
  logic [KEYS-1:0]  irqen_r;
  logic [KEYS-1:0]  irqen_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W:0]   sum_s;
  logic [7:0]       rise8_s;
  logic             irq_r;
  logic [31:0]      rdata_s;

  for (genvar i = 0; i < KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_LVL         (KEY_PIN_RESET[i])
    ) u_deb (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
      .key_raw  (user_key[i]),
      .stable   (stable_s[i]),
      .rise     (rise_s[i])
    );
  end

  // Next register state: press set beats W1C clear, a COUNT write drops same-cycle events.
  always_comb begin
    rise8_s             = 8'h00;
    rise8_s[KEYS-1:0]   = rise_s;
    sum_s               = {1'b0, count_r} + (CNT_W+1)'(popcount8(rise8_s));
    if (bus.we && (key_reg_e'(bus.addr) == KEY_PRESS)) begin
      clr_s = bus.wdata[KEYS-1:0];
    end else begin
      clr_s = {KEYS{1'b0}};
    end
    press_nxt_s = (press_r & ~clr_s) | rise_s;
    if (bus.we && (key_reg_e'(bus.addr) == KEY_IRQEN)) begin
      irqen_nxt_s = bus.wdata[KEYS-1:0];
    end else begin
      irqen_nxt_s = irqen_r;
    end
    if (bus.we && (key_reg_e'(bus.addr) == KEY_COUNT)) begin
      count_nxt_s = bus.wdata[CNT_W-1:0];
    end else if (sum_s[CNT_W]) begin
      count_nxt_s = {CNT_W{1'b1}};
    end else begin
      count_nxt_s = sum_s[CNT_W-1:0];
    end
  end

  // Register file and interrupt flop; irq looks at next-state so it tracks the same edge.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      press_r <= {KEYS{1'b0}};
      irqen_r <= {KEYS{1'b0}};
      count_r <= {CNT_W{1'b0}};
      irq_r   <= 1'b0;
    end else begin
      press_r <= press_nxt_s;
      irqen_r <= irqen_nxt_s;
      count_r <= count_nxt_s;
      irq_r   <= |(press_nxt_s & irqen_nxt_s);
    end
  end

  // Combinational read mux; unused upper bits read as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (key_reg_e'(bus.addr))
      KEY_STATUS: rdata_s[KEYS-1:0]  = stable_s;
      KEY_PRESS:  rdata_s[KEYS-1:0]  = press_r;
      KEY_IRQEN:  rdata_s[KEYS-1:0]  = irqen_r;
      KEY_COUNT:  rdata_s[CNT_W-1:0] = count_r;
      default:    rdata_s            = 32'h0000_0000;
    endcase
  end

  assign bus.rdata = rdata_s;
  assign bus.irq   = irq_r;

endmodule
